mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
//  Multi-cycle multiply/divide unit in the E stage of the pipelined MIPS core; owns HI/LO.
//  Its hi/lo outputs feed the E-stage 4:1 result mux (mfhi/mflo path) that forwards into M.
//  Exposes busy so the hazard unit stalls D-stage MDU instructions while an operation runs.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles for MULT/MULTU (>=1)
//  DIV_CYCLES   10  busy cycles for DIV/DIVU (>=1)
// PORTS
//  clk     in   1   core clock, all state on rising edge
//  reset   in   1   asynchronous, active-high; clears all state immediately
//  start   in   1   one-cycle request from E-stage decode
//  op      in   3   0 MULT,1 MULTU,2 DIV,3 DIVU,4 MTHI,5 MTLO, 6-7 no-op
//  cancel  in   1   E-stage exception/interrupt: suppresses start in same cycle
//  a       in   32  rs operand
//  b       in   32  rt operand
//  busy    out  1   operation in flight, registered
//  hi      out  32  architectural HI, registered
//  lo      out  32  architectural LO, registered
// BEHAVIOUR
//  Reset (async, any time): busy=0, hi=0, lo=0, cnt=0, state IDLE; in-flight op discarded.
//  Accept = start & ~cancel & ~busy. start while busy or with cancel=1: ignored, no state change.
//  States: IDLE, RUN.
//  IDLE, accept MULT/MULTU: latch 64-bit product into pend_hi/pend_lo, cnt<=MULT_CYCLES-1,
//   busy<=1, -> RUN. DIV/DIVU same with cnt<=DIV_CYCLES-1.
//  IDLE, accept MTHI/MTLO: hi<=a (or lo<=a) at that edge; busy stays 0; stays IDLE.
//  IDLE, accept op 6/7: nothing.
//  RUN: cnt decrements each edge; at edge where cnt==0: hi<=pend_hi, lo<=pend_lo,
//   busy<=0, -> IDLE. Hence busy high exactly N cycles after the accept edge;
//   new hi/lo visible in the cycle busy first reads 0.
//  hi/lo hold old values throughout RUN (mfhi cannot issue then; hazard unit stalls).
//  cancel during RUN has no effect: the accepted op completes (it already committed).
//  MULT: signed 32x32->64, hi=[63:32], lo=[31:0]. MULTU: unsigned.
//  DIV: signed, lo=quotient truncated toward zero, hi=remainder with sign of dividend.
//  DIVU: unsigned quotient/remainder.
//  DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (no trap).
//  b==0 on DIV/DIVU: busy sequence runs normally, hi/lo left unchanged at completion.
//  Operands are sampled only at accept; a/b changes during RUN are ignored.
//  Edge where RUN completes and start arrives: start ignored (busy still 1 that cycle).
// STRUCTURE
//  Shared defs package/header mdu_defs: op encodings MDU_MULT..MDU_MTLO, used by
//   controller, hazard unit and this block.
//  No sub-module: product/quotient from synthesis operators, registered at accept.
//  Single always block for async-reset state, counter and HI/LO.
// TESTING
//  MULT a=0xFFFFFFFE(-2), b=3 -> busy 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
//  DIVU a=100, b=7 -> busy 10 cycles, then lo=14, hi=2; DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//  MTHI a=0x12345678 -> hi=0x12345678 next edge, busy never set;
//   start+cancel with MULT -> no busy, hi/lo unchanged.
//  DIV b=0 after hi=1, lo=2 -> busy 10 cycles, hi=1, lo=2 after;
//   INT_MIN/-1 -> lo=0x80000000, hi=0.
//  Reset asserted mid-DIV (cycle 4) -> busy/hi/lo=0 immediately without clock;
//   after release, MULT 6*7 -> lo=42.
//  start MULTU during RUN of a DIV -> ignored; only the DIV result lands,
//   busy drops exactly at cycle 10.

Source files
------------

// File: rtl/mdu_defs.sv
// Shared multiply/divide definitions: op encodings used by the decoder, the hazard unit
// and the MDU itself, plus the MDU sequencing states.
package mdu_defs;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } mdu_state_e;

endpackage

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO. The result is computed at accept and
// held in pend_hi/pend_lo until the busy window expires.
module mult_div_unit
  import mdu_defs::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic        cancel,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  // state | meaning
  // IDLE  | no op in flight; MTHI/MTLO write directly, MULT/DIV launch
  // RUN   | counting down the busy window; pending result lands at cnt==0
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  mdu_state_e  state, state_nxt;
  logic [CW-1:0] cnt;
  logic [31:0] pend_hi, pend_lo;
  logic        pend_wr;

  logic        accept, is_mul, is_div, is_signed, start_run, complete;
  logic        load_hi, load_lo;

  logic [63:0] prod_s, prod_u, prod;
  logic [31:0] a_mag, b_mag, div_n, div_d, quo, rem, quo_fin, rem_fin;
  logic [31:0] res_hi, res_lo;

  // Low 64 bits of the sign-extended product equal the signed 32x32 product.
  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'd0, a} * {32'd0, b};
  assign prod   = (op == MDU_MULT) ? prod_s : prod_u;

  // Signed divide via magnitudes avoids the INT_MIN / -1 overflow case entirely.
  assign is_signed = (op == MDU_DIV);
  assign a_mag     = a[31] ? (32'd0 - a) : a;
  assign b_mag     = b[31] ? (32'd0 - b) : b;
  assign div_n     = is_signed ? a_mag : a;
  assign div_d     = is_signed ? b_mag : b;
  assign quo       = div_n / div_d;
  assign rem       = div_n % div_d;
  assign quo_fin   = (is_signed && (a[31] ^ b[31])) ? (32'd0 - quo) : quo;
  assign rem_fin   = (is_signed && a[31]) ? (32'd0 - rem) : rem;

  assign res_hi = is_mul ? prod[63:32] : rem_fin;
  assign res_lo = is_mul ? prod[31:0]  : quo_fin;

  // Output/control decode
  always_comb begin
    accept    = start & ~cancel & ~busy;
    is_mul    = (op == MDU_MULT) || (op == MDU_MULTU);
    is_div    = (op == MDU_DIV)  || (op == MDU_DIVU);
    start_run = accept && (state == S_IDLE) && (is_mul || is_div);
    load_hi   = accept && (state == S_IDLE) && (op == MDU_MTHI);
    load_lo   = accept && (state == S_IDLE) && (op == MDU_MTLO);
    complete  = (state == S_RUN) && (cnt == '0);
  end

  // Next-state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_run) state_nxt = S_RUN;
      S_RUN:   if (complete)  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      busy    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_wr <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start_run) begin
        busy    <= 1'b1;
        cnt     <= is_mul ? CW'(MULT_CYCLES - 1) : CW'(DIV_CYCLES - 1);
        pend_hi <= res_hi;
        pend_lo <= res_lo;
        // Divide by zero runs the full window but leaves HI/LO untouched.
        pend_wr <= ~(is_div && (b == 32'd0));
      end else if (state == S_RUN) begin
        if (complete) begin
          busy <= 1'b0;
          if (pend_wr) begin
            hi <= pend_hi;
            lo <= pend_lo;
          end
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
      if (load_hi) hi <= a;
      if (load_lo) lo <= a;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: busy window lengths, HI/LO results, cancel,
// divide-by-zero, async reset mid-operation and starts ignored while busy.
module tb_mult_div_unit;
  import mdu_defs::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic        cancel;
  logic [31:0] a, b;
  logic        busy;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_bad = 0;
  int n;

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .cancel(cancel),
    .a(a), .b(b), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Presents a one-cycle request; returns at the negedge after the accept edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic c);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y; cancel = c;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0; op = 3'd6;
  endtask

  // Counts negedges with busy high, bounded so a stuck busy still terminates.
  task automatic count_busy(output int cycles);
    cycles = 0;
    while (busy && cycles < 50) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; op = 3'd6; cancel = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (hi !== 32'h0) begin n_bad++; $display("FAIL reset_hi got %h want 0", hi); end
    n_cmp++; if (lo !== 32'h0) begin n_bad++; $display("FAIL reset_lo got %h want 0", lo); end
  endtask

  task automatic test_mult;
    issue(MDU_MULT, 32'hFFFFFFFE, 32'd3, 1'b0);
    n_cmp++; if (hi !== 32'h0) begin n_bad++; $display("FAIL mult_hold_hi got %h want 0", hi); end
    count_busy(n);
    n_cmp++; if (n !== 5) begin n_bad++; $display("FAIL mult_cycles got %0d want 5", n); end
    n_cmp++; if (hi !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL mult_hi got %h want ffffffff", hi); end
    n_cmp++; if (lo !== 32'hFFFFFFFA) begin n_bad++; $display("FAIL mult_lo got %h want fffffffa", lo); end
    issue(MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    count_busy(n);
    n_cmp++; if (hi !== 32'hFFFFFFFE) begin n_bad++; $display("FAIL multu_hi got %h want fffffffe", hi); end
    n_cmp++; if (lo !== 32'h00000001) begin n_bad++; $display("FAIL multu_lo got %h want 00000001", lo); end
  endtask

  task automatic test_div;
    issue(MDU_DIVU, 32'd100, 32'd7, 1'b0);
    n_cmp++; if (lo !== 32'h00000001) begin n_bad++; $display("FAIL divu_hold_lo got %h want 00000001", lo); end
    count_busy(n);
    n_cmp++; if (n !== 10) begin n_bad++; $display("FAIL divu_cycles got %0d want 10", n); end
    n_cmp++; if (lo !== 32'd14) begin n_bad++; $display("FAIL divu_lo got %h want 0000000e", lo); end
    n_cmp++; if (hi !== 32'd2) begin n_bad++; $display("FAIL divu_hi got %h want 00000002", hi); end
    issue(MDU_DIV, 32'hFFFFFFF9, 32'd2, 1'b0);
    count_busy(n);
    n_cmp++; if (lo !== 32'hFFFFFFFD) begin n_bad++; $display("FAIL div_lo got %h want fffffffd", lo); end
    n_cmp++; if (hi !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL div_hi got %h want ffffffff", hi); end
  endtask

  task automatic test_mt_cancel;
    issue(MDU_MTHI, 32'h12345678, 32'd0, 1'b0);
    n_cmp++; if (hi !== 32'h12345678) begin n_bad++; $display("FAIL mthi_hi got %h want 12345678", hi); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mthi_busy got %b want 0", busy); end
    issue(MDU_MTLO, 32'hCAFEF00D, 32'd0, 1'b0);
    n_cmp++; if (lo !== 32'hCAFEF00D) begin n_bad++; $display("FAIL mtlo_lo got %h want cafef00d", lo); end
    issue(MDU_MULT, 32'd9, 32'd9, 1'b1);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL cancel_busy got %b want 0", busy); end
    repeat (6) @(negedge clk);
    n_cmp++; if (hi !== 32'h12345678) begin n_bad++; $display("FAIL cancel_hi got %h want 12345678", hi); end
    n_cmp++; if (lo !== 32'hCAFEF00D) begin n_bad++; $display("FAIL cancel_lo got %h want cafef00d", lo); end
    issue(3'd6, 32'd1, 32'd1, 1'b0);
    n_cmp++; if (busy !== 1'b0 || hi !== 32'h12345678 || lo !== 32'hCAFEF00D) begin
      n_bad++; $display("FAIL nop_state got busy=%b hi=%h lo=%h want 0/12345678/cafef00d", busy, hi, lo);
    end
  endtask

  task automatic test_div_edge;
    issue(MDU_MTHI, 32'd1, 32'd0, 1'b0);
    issue(MDU_MTLO, 32'd2, 32'd0, 1'b0);
    issue(MDU_DIV, 32'd55, 32'd0, 1'b0);
    count_busy(n);
    n_cmp++; if (n !== 10) begin n_bad++; $display("FAIL divzero_cycles got %0d want 10", n); end
    n_cmp++; if (hi !== 32'd1) begin n_bad++; $display("FAIL divzero_hi got %h want 00000001", hi); end
    n_cmp++; if (lo !== 32'd2) begin n_bad++; $display("FAIL divzero_lo got %h want 00000002", lo); end
    issue(MDU_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    count_busy(n);
    n_cmp++; if (lo !== 32'h80000000) begin n_bad++; $display("FAIL intmin_lo got %h want 80000000", lo); end
    n_cmp++; if (hi !== 32'h0) begin n_bad++; $display("FAIL intmin_hi got %h want 0", hi); end
  endtask

  task automatic test_reset_mid;
    issue(MDU_MTHI, 32'hAAAA5555, 32'd0, 1'b0);
    issue(MDU_DIV, 32'd1000, 32'd3, 1'b0);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy got %b want 0", busy); end
    n_cmp++; if (hi !== 32'h0) begin n_bad++; $display("FAIL rstmid_hi got %h want 0", hi); end
    n_cmp++; if (lo !== 32'h0) begin n_bad++; $display("FAIL rstmid_lo got %h want 0", lo); end
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    n_cmp++; if (hi !== 32'h0) begin n_bad++; $display("FAIL rstmid_discard_hi got %h want 0", hi); end
    issue(MDU_MULT, 32'd6, 32'd7, 1'b0);
    count_busy(n);
    n_cmp++; if (lo !== 32'd42) begin n_bad++; $display("FAIL rstmid_mult_lo got %h want 0000002a", lo); end
    n_cmp++; if (hi !== 32'd0) begin n_bad++; $display("FAIL rstmid_mult_hi got %h want 0", hi); end
  endtask

  task automatic test_back_to_back;
    issue(MDU_DIVU, 32'd100, 32'd7, 1'b0);
    n = 0;
    while (busy && n < 50) begin
      n++;
      // Retry at cycle 3 and on the completion edge itself; both must be dropped.
      if (n == 3 || n == 10) begin
        start = 1'b1; op = MDU_MULTU; a = 32'd5; b = 32'd5;
      end else begin
        start = 1'b0; op = 3'd6;
      end
      @(negedge clk);
    end
    start = 1'b0; op = 3'd6;
    n_cmp++; if (n !== 10) begin n_bad++; $display("FAIL b2b_cycles got %0d want 10", n); end
    n_cmp++; if (lo !== 32'd14) begin n_bad++; $display("FAIL b2b_lo got %h want 0000000e", lo); end
    n_cmp++; if (hi !== 32'd2) begin n_bad++; $display("FAIL b2b_hi got %h want 00000002", hi); end
    repeat (6) @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || lo !== 32'd14) begin
      n_bad++; $display("FAIL b2b_after got busy=%b lo=%h want 0/0000000e", busy, lo);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_mt_cancel();
    test_div_edge();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
